// File: rtl/Stark_pkg.sv
// Types shared by the Stark FPU station logic.
package Stark_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHK  = 2'd1,
    BUSY = 2'd2
  } sched_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types used across the out-of-order core.
package cpu_types_pkg;
  localparam int ROB_NDX_W = 6;
  typedef logic [ROB_NDX_W-1:0] rob_ndx_t;
endpackage

// File: rtl/stark_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module stark_rr_pick #(
  parameter int NREQ = 8,
  localparam int PW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  always_comb begin
    logic [PW-1:0] cand;
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    // NREQ is a power of two, so the PW-bit add wraps modulo NREQ for free.
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr_i + PW'(i);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    onehot_o[idx_o] = any_o;
  end

endmodule

// File: rtl/stark_fpu_sched.sv
// Issue scheduler for one Stark FPU reservation station: round-robin issue,
// then holds the station busy for multicycle ops until done, timeout or flush.
module stark_fpu_sched
  import cpu_types_pkg::*;
  import Stark_pkg::*;
#(
  parameter int NREQ  = 8,
  parameter int LAT_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_v,
  input  rob_ndx_t [NREQ-1:0]        req_ndx,
  input  logic [NREQ-1:0]            req_mc,
  input  logic [NREQ-1:0][LAT_W-1:0] req_lat,
  input  logic                       sc_done,
  input  logic                       fpu_done,
  input  logic                       flush,
  output logic [NREQ-1:0]            grant,
  output rob_ndx_t                   rndx,
  output logic                       rndxv,
  output logic                       available,
  output logic                       idle,
  output logic                       busy_timeout,
  output logic [31:0]                issue_cnt
);

  localparam int PW = $clog2(NREQ);

  sched_state_t     state_q;
  logic [PW-1:0]    rr_ptr_q;
  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] win_lat_q;
  logic             win_mc_q;
  logic             tmo_q;
  logic             run_q;
  logic [31:0]      issue_cnt_q;

  logic [NREQ-1:0]  pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic             is_idle;

  function automatic logic [LAT_W-1:0] eff_lat(input logic [LAT_W-1:0] l);
    return (l == '0) ? LAT_W'(1) : l;
  endfunction

  stark_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (req_v),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // run_q keeps grants off until the first rising edge after reset releases.
  assign is_idle      = (state_q == IDLE);
  assign rndxv        = is_idle & run_q & pick_any & ~flush;
  assign grant        = rndxv ? pick_oh : '0;
  assign rndx         = rndxv ? req_ndx[pick_idx] : '0;
  assign idle         = is_idle;
  assign available    = is_idle;
  assign busy_timeout = tmo_q;
  assign issue_cnt    = issue_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      win_lat_q   <= '0;
      win_mc_q    <= 1'b0;
      tmo_q       <= 1'b0;
      run_q       <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      run_q <= 1'b1;
      tmo_q <= 1'b0;
      if (flush) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rndxv) begin
              win_mc_q    <= req_mc[pick_idx];
              win_lat_q   <= eff_lat(req_lat[pick_idx]);
              rr_ptr_q    <= pick_idx + 1'b1;
              issue_cnt_q <= issue_cnt_q + 32'd1;
              state_q     <= CHK;
            end
          end
          CHK: begin
            if (sc_done || !win_mc_q) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= win_lat_q;
              state_q <= BUSY;
            end
          end
          BUSY: begin
            // Completion takes priority over an expiring budget.
            if (fpu_done) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else if (cnt_q == LAT_W'(1)) begin
              cnt_q   <= '0;
              tmo_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stark_fpu_sched.sv
// Directed bench for stark_fpu_sched with a grant scoreboard.
module tb_stark_fpu_sched;
  import cpu_types_pkg::*;

  logic             clk;
  logic             rst;
  logic [7:0]       req_v;
  rob_ndx_t [7:0]   req_ndx;
  logic [7:0]       req_mc;
  logic [7:0][5:0]  req_lat;
  logic             sc_done;
  logic             fpu_done;
  logic             flush;
  logic [7:0]       grant;
  rob_ndx_t         rndx;
  logic             rndxv;
  logic             available;
  logic             idle;
  logic             busy_timeout;
  logic [31:0]      issue_cnt;

  typedef struct {
    int       slot;
    rob_ndx_t ndx;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   tmo_seen = 0;
  int   low;

  stark_fpu_sched #(.NREQ(8), .LAT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_v        (req_v),
    .req_ndx      (req_ndx),
    .req_mc       (req_mc),
    .req_lat      (req_lat),
    .sc_done      (sc_done),
    .fpu_done     (fpu_done),
    .flush        (flush),
    .grant        (grant),
    .rndx         (rndx),
    .rndxv        (rndxv),
    .available    (available),
    .idle         (idle),
    .busy_timeout (busy_timeout),
    .issue_cnt    (issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every valid issue must match the oldest expected grant.
  always @(negedge clk) begin
    logic [7:0] exp_oh;
    exp_t       e;
    if (busy_timeout === 1'b1) tmo_seen++;
    if (rndxv === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_grant", 32'(grant), 32'd0);
      end else begin
        e = sb_q.pop_front();
        exp_oh = '0;
        exp_oh[e.slot] = 1'b1;
        check("sb_grant", 32'(grant), 32'(exp_oh));
        check("sb_rndx", 32'(rndx), 32'(e.ndx));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int slot, input logic exp_idle);
    if (slot >= 0) sb_q.push_back('{slot, req_ndx[slot]});
    #2;
    check("rndxv", 32'(rndxv), 32'(slot >= 0));
    check("idle", 32'(idle), 32'(exp_idle));
    check("available", 32'(available), 32'(exp_idle));
    if (slot < 0) check("no_grant", 32'(grant), 32'd0);
  endtask

  initial begin
    rst      = 1'b0;
    req_v    = 8'hFF;
    req_mc   = '0;
    req_lat  = '0;
    sc_done  = 1'b0;
    fpu_done = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < 8; i++) req_ndx[i] = rob_ndx_t'(3 * i + 1);

    // Reset held with all requests pending
    repeat (2) nxt();
    #2;
    check("rst_rndxv", 32'(rndxv), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_available", 32'(available), 32'd1);
    check("rst_issue_cnt", issue_cnt, 32'd0);
    check("rst_rndx", 32'(rndx), 32'd0);
    check("rst_timeout", 32'(busy_timeout), 32'd0);
    nxt(); rst = 1'b1; chk(-1, 1'b1);
    nxt(); chk(0, 1'b1);

    // Round-robin between slots 0 and 7
    nxt(); req_v = 8'h81; chk(-1, 1'b0);
    check("rr_issue_cnt1", issue_cnt, 32'd1);
    nxt(); chk(7, 1'b1);
    nxt(); chk(-1, 1'b0);
    nxt(); chk(0, 1'b1);
    nxt(); req_v = 8'h00; chk(-1, 1'b0);
    check("rr_issue_cnt3", issue_cnt, 32'd3);

    // Single-cycle op with ROB index 5
    nxt(); req_v = 8'h04; req_ndx[2] = rob_ndx_t'(5); chk(2, 1'b1);
    check("sc_rndx", 32'(rndx), 32'd5);
    nxt(); req_v = 8'h00; chk(-1, 1'b0);
    nxt(); chk(-1, 1'b1);
    check("sc_issue_cnt", issue_cnt, 32'd4);

    // Multicycle op, budget 10, fpu_done four cycles after BUSY entry
    nxt(); req_v = 8'h10; req_mc[4] = 1'b1; req_lat[4] = 6'd10; chk(4, 1'b1);
    low = 0;
    for (int n = 1; n <= 20; n++) begin
      nxt();
      req_v = 8'h00;
      fpu_done = (n == 6);
      #2;
      if (idle) break;
      low++;
    end
    fpu_done = 1'b0;
    check("mc_idle_low_cycles", 32'(low), 32'd6);
    check("mc_no_timeout", 32'(tmo_seen), 32'd0);

    // Timeout with budget 3, slot 6 pending throughout
    nxt(); req_v = 8'h20; req_mc[5] = 1'b1; req_lat[5] = 6'd3; chk(5, 1'b1);
    nxt(); req_v = 8'h40; chk(-1, 1'b0);
    nxt(); chk(-1, 1'b0);
    nxt(); chk(-1, 1'b0);
    nxt(); chk(-1, 1'b0);
    nxt(); chk(6, 1'b1);
    check("tmo_pulse", 32'(busy_timeout), 32'd1);
    nxt(); req_v = 8'h00; chk(-1, 1'b0);
    check("tmo_pulse_end", 32'(busy_timeout), 32'd0);
    nxt(); chk(-1, 1'b1);
    check("tmo_issue_cnt", issue_cnt, 32'd7);

    // Flush in BUSY; pointer wraps from 7 to slot 0
    nxt(); req_v = 8'h01; req_mc[0] = 1'b1; req_lat[0] = 6'd8; chk(0, 1'b1);
    nxt(); req_v = 8'h02; chk(-1, 1'b0);
    nxt(); chk(-1, 1'b0);
    nxt(); flush = 1'b1; chk(-1, 1'b0);
    nxt(); flush = 1'b0; chk(1, 1'b1);
    check("flush_issue_cnt_hold", issue_cnt, 32'd8);
    nxt(); req_v = 8'h00; chk(-1, 1'b0);
    check("flush_issue_cnt_inc", issue_cnt, 32'd9);
    nxt(); chk(-1, 1'b1);

    // Flush in IDLE suppresses the grant
    nxt(); req_v = 8'h08; flush = 1'b1; chk(-1, 1'b1);
    nxt(); flush = 1'b0; chk(3, 1'b1);
    nxt(); req_v = 8'h00; chk(-1, 1'b0);
    check("idle_flush_issue_cnt", issue_cnt, 32'd10);
    nxt(); chk(-1, 1'b1);

    // Zero budget behaves as one cycle
    nxt(); req_v = 8'h10; req_lat[4] = 6'd0; chk(4, 1'b1);
    nxt(); req_v = 8'h00; chk(-1, 1'b0);
    nxt(); chk(-1, 1'b0);
    nxt(); chk(-1, 1'b1);
    check("lat0_timeout", 32'(busy_timeout), 32'd1);

    // fpu_done coincides with the last budget cycle
    nxt(); req_v = 8'h20; chk(5, 1'b1);
    nxt(); req_v = 8'h00; chk(-1, 1'b0);
    nxt(); chk(-1, 1'b0);
    nxt(); chk(-1, 1'b0);
    nxt(); fpu_done = 1'b1; chk(-1, 1'b0);
    nxt(); fpu_done = 1'b0; chk(-1, 1'b1);
    check("done_beats_timeout", 32'(busy_timeout), 32'd0);

    // sc_done in CHK ends a multicycle op early
    nxt(); req_v = 8'h40; req_mc[6] = 1'b1; req_lat[6] = 6'd5; chk(6, 1'b1);
    nxt(); req_v = 8'h00; sc_done = 1'b1; chk(-1, 1'b0);
    nxt(); sc_done = 1'b0; chk(-1, 1'b1);

    // Asynchronous reset mid-BUSY; sc_done in BUSY is ignored
    nxt(); req_v = 8'h80; req_mc[7] = 1'b1; req_lat[7] = 6'd10; chk(7, 1'b1);
    nxt(); req_v = 8'h00; chk(-1, 1'b0);
    nxt(); sc_done = 1'b1; chk(-1, 1'b0);
    nxt(); sc_done = 1'b0; chk(-1, 1'b0);
    rst = 1'b0; req_v = 8'hFF; req_mc = '0;
    #1;
    check("arst_idle", 32'(idle), 32'd1);
    check("arst_rndxv", 32'(rndxv), 32'd0);
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_issue_cnt", issue_cnt, 32'd0);
    nxt(); rst = 1'b1; chk(-1, 1'b1);
    nxt(); chk(0, 1'b1);
    nxt(); req_v = 8'h00; chk(-1, 1'b0);
    nxt(); chk(-1, 1'b1);
    check("arst_issue_cnt_after", issue_cnt, 32'd1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("timeout_total", 32'(tmo_seen), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stark_fpu_sched.md
# stark_fpu_sched

Issue scheduler for one Stark FPU reservation station. Arbitrates round-robin among up to NREQ ready ROB candidates, presents one winner per issue window on the station's `rndx`/`rndxv`/`available`/`idle` inputs, and holds the station busy for multicycle ops until the FPU reports completion, the latency budget expires, or a flush occurs. Sits between the ROB ready-scan and the FPU station.

## Interface
- NREQ, 8: number of candidate slots; power of two, 2..16.
- LAT_W, 6: width of the per-request latency budget and the busy counter.
- clk  input  1  clock; all state on rising edge.
- rst  input  1  one clock; reset is asynchronous and active-low.
- req_v  input  NREQ  candidate valid and operands renamed.
- req_ndx  input  rob_ndx_t[NREQ]  ROB index per candidate.
- req_mc  input  NREQ  candidate is a multicycle op.
- req_lat  input  [NREQ][LAT_W]  max busy cycles for a multicycle op; 0 means 1.
- sc_done  input  1  station single-cycle-done pulse.
- fpu_done  input  1  FPU multicycle completion pulse.
- flush  input  1  pipeline flush; abandons the current op.
- grant  output  NREQ  one-hot pulse; winner removes itself from req_v next cycle.
- rndx  output  rob_ndx_t  ROB index to the station.
- rndxv  output  1  rndx valid.
- available  output  1  station may accept.
- idle  output  1  scheduler in IDLE.
- busy_timeout  output  1  pulse: budget expired without fpu_done.
- issue_cnt  output  32  count of issued ops; wraps.

## Operation
- States (sched_state_t): IDLE, CHK, BUSY.
- IDLE:
  - idle=1, available=1.
  - rndxv = |req_v & !flush.
  - Winner = first set req_v at or after rr_ptr, wrapping modulo NREQ.
  - rndx=req_ndx[win]; grant[win]=rndxv.
  - On rndxv: latch win_mc and win_lat (0 forced to 1), rr_ptr <= win+1 mod NREQ, issue_cnt++, go CHK.
- CHK (station latched the op at the previous edge; its sc_done is visible now):
  - idle=0, available=0, rndxv=0, grant=0.
  - sc_done=1 or win_mc=0: go IDLE.
  - Otherwise: cnt <= win_lat, go BUSY.
- BUSY:
  - Outputs as in CHK.
  - fpu_done=1: go IDLE.
  - Else if cnt==1: busy_timeout pulse, go IDLE.
  - Else cnt <= cnt-1.
- flush (any state) has priority over all other transitions:
  - Next state IDLE, cnt <= 0.
  - No grant in the flush cycle.
  - issue_cnt and rr_ptr unchanged.
  - No timeout pulse.
- fpu_done and cnt==1 in the same cycle: completion wins, no timeout.
- sc_done or fpu_done outside the expected state: ignored.

## Timing
- Reset values: state=IDLE, rr_ptr=0, cnt=0, issue_cnt=0, busy_timeout=0. Consequently idle=1, available=1, rndxv=0, grant=0, rndx=0.
- rndx, rndxv, grant, idle, available are combinational from registered state plus req_v/req_ndx/flush. No register between the request and the grant.
- Single-cycle op: issue every 2 cycles (IDLE, CHK, IDLE, ...).
- Multicycle op with budget L: occupancy is 2+k cycles, where fpu_done arrives k cycles after BUSY entry, capped at 1+L.
- The busy_timeout pulse is registered: it is high the cycle after cnt==1 in BUSY.
- Asynchronous reset mid-BUSY: immediate return to IDLE with the reset values above. No grant until rst deasserts and the next rising edge.

## Structure
- sched_state_t belongs in Stark_pkg. rob_ndx_t comes from cpu_types_pkg.
- Round-robin picker is a separate sub-module, stark_rr_pick:
  - Inputs: req vector, pointer.
  - Outputs: one-hot winner, encoded index, any.
  - Purely combinational; reused by other station schedulers.
- Counters and the FSM live in stark_fpu_sched.

## Test plan
- Reset: hold rst=0 with req_v=8'hFF. Required: rndxv=0, grant=0, idle=1, issue_cnt=0. After release, the first grant is slot 0.
- Round-robin: keep req_v=8'h81 continuously asserted. Required: grants alternate slot 0, slot 7, slot 0, one every 2 cycles.
- Single-cycle op: issue req_mc=0 with req_ndx=5. Required: rndx=5 and rndxv=1 for exactly one cycle, IDLE again 2 cycles later, issue_cnt=1.
- Multicycle op: req_mc=1, req_lat=10, fpu_done 4 cycles after BUSY entry. Required: idle low for 6 cycles total, no busy_timeout.
- Timeout: req_mc=1, req_lat=3, no fpu_done. Required: busy_timeout pulses once, return to IDLE 5 cycles after issue. A pending request is granted next.
- Flush: assert flush in BUSY with req_v set. Required: IDLE next cycle, no grant in the flush cycle, grant in the following cycle, issue_cnt incremented only by that grant.
